// File: rtl/iobuf_vec_ctl_pkg.sv
// Shared types for the tri-state pin vector controller and its arbiter.
// The optional synchronizer is selected by IOBUF_VEC_CTL_SYNC_EN in the top.
package iobuf_vec_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2,
    SAMPLE = 2'd3
  } ctl_state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  localparam int TURN_CNT_W = 4;

  // Request/grant bit positions shared by the controller and the arbiter.
  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

endpackage

// File: rtl/iobuf_rr_arb2.sv
// Two-requester round-robin arbiter: on contention the priority holder wins
// and priority passes to the other side once the grant is consumed.
module iobuf_rr_arb2 #(
  parameter logic RST_PRI = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_pri
);

  logic r_pri;

  always_comb begin
    o_grant = 2'b00;
    if (&i_req) o_grant[r_pri] = 1'b1;
    else        o_grant = i_req;
  end

  // Priority only moves when both sides competed for the grant.
  always_ff @(posedge i_clk) begin
    if (i_rst)                       r_pri <= RST_PRI;
    else if (i_advance && (&i_req))  r_pri <= ~r_pri;
  end

  assign o_pri = r_pri;

endmodule

// File: rtl/iobuf_vec_ctl.sv
// Sequences a shared tri-state pin vector between a write and a read port,
// owning T, inserting turnaround gaps; IOBUF_VEC_CTL_SYNC_EN adds an input synchronizer.
module iobuf_vec_ctl
  import iobuf_vec_ctl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] pins_I,
  output logic             pins_T,
  input  logic [WIDTH-1:0] pins_O,
  output logic             busy
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("iobuf_vec_ctl: TURN_CYCLES must be in 1..15");
  end

  localparam logic [TURN_CNT_W-1:0] TC = TURN_CNT_W'(TURN_CYCLES);

  logic [WIDTH-1:0] w_pins_s;

`ifdef IOBUF_VEC_CTL_SYNC_EN
  localparam logic [1:0] SMP_EXTRA = 2'd2;
  logic [WIDTH-1:0] r_sync1, r_sync2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pins_O;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pins_s = r_sync2;
`else
  localparam logic [1:0] SMP_EXTRA = 2'd0;
  assign w_pins_s = pins_O;
`endif

  ctl_state_t             r_state, r_tgt;
  dir_t                   r_last_dir;
  logic [TURN_CNT_W-1:0]  r_turn_cnt;
  logic [1:0]             r_smp_cnt;
  logic [WIDTH-1:0]       r_wdata, r_pins_I, r_rd_data;
  logic                   r_pins_T, r_rd_valid;
  logic                   w_idle, w_pri;
  logic [1:0]             w_req, w_gnt;

  assign w_idle = (r_state == IDLE);
  assign w_req  = {rd_req, wr_valid};

  iobuf_rr_arb2 #(.RST_PRI(1'(REQ_WR))) u_arb (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_req     (w_req),
    .i_advance (w_idle),
    .o_grant   (w_gnt),
    .o_pri     (w_pri)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_tgt      <= IDLE;
      r_last_dir <= DIR_READ;
      r_turn_cnt <= '0;
      r_smp_cnt  <= '0;
      r_wdata    <= '0;
      r_pins_I   <= '0;
      r_pins_T   <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt[REQ_WR]) begin
            r_wdata <= wr_data;
            r_tgt   <= DRIVE;
            if (r_last_dir == DIR_WRITE) begin
              // Bus already parked driven: straight back into DRIVE.
              r_state  <= DRIVE;
              r_pins_T <= 1'b0;
              r_pins_I <= wr_data;
            end else begin
              r_state    <= TURN;
              r_turn_cnt <= TC;
              r_pins_T   <= 1'b1;
            end
          end else if (w_gnt[REQ_RD]) begin
            r_tgt <= SAMPLE;
            if (r_last_dir == DIR_READ) begin
              r_state   <= SAMPLE;
              r_smp_cnt <= SMP_EXTRA;
            end else begin
              r_state    <= TURN;
              r_turn_cnt <= TC;
              r_pins_T   <= 1'b1;
            end
          end
        end
        TURN: begin
          r_turn_cnt <= r_turn_cnt - TURN_CNT_W'(1);
          if (r_turn_cnt <= TURN_CNT_W'(1)) begin
            r_state <= r_tgt;
            if (r_tgt == DRIVE) begin
              r_pins_T <= 1'b0;
              r_pins_I <= r_wdata;
            end else begin
              r_smp_cnt <= SMP_EXTRA;
            end
          end
        end
        DRIVE: begin
          r_last_dir <= DIR_WRITE;
          r_state    <= IDLE;
        end
        SAMPLE: begin
          if (r_smp_cnt == 2'd0) begin
            r_rd_data  <= w_pins_s;
            r_rd_valid <= 1'b1;
            r_last_dir <= DIR_READ;
            r_state    <= IDLE;
          end else begin
            r_smp_cnt <= r_smp_cnt - 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ready = w_idle & w_gnt[REQ_WR];
  assign rd_ready = w_idle & w_gnt[REQ_RD];
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign pins_I   = r_pins_I;
  assign pins_T   = r_pins_T;
  assign busy     = ~w_idle;

  logic w_unused;
  assign w_unused = w_pri;

endmodule

// File: doc/iobuf_vec_ctl.md
Name: iobuf_vec_ctl

Overview:
- Sequences a shared tri-state pin vector (IobufVec-style: per-bit I/O, single T enable) between two requesters.
  - A write port drives words onto the pins.
  - A read port samples words from the pins.
- Owns the T enable, inserts bus-turnaround idle cycles on every direction change, and arbitrates round-robin when both requesters are pending.
- Sits between protocol engines (e.g. a parallel flash/SRAM master) and the IobufVec instance.

Parameters:
- WIDTH, 8, pin vector width (bits of I/O).
- TURN_CYCLES, 1, hi-Z cycles inserted on a direction change; legal range 1..15.

Ports:
- CLK  input  1  sole clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request pending.
- wr_data  input  WIDTH  word to drive.
- wr_ready  output  1  write accepted this cycle (valid & ready = transfer).
- rd_req  input  1  read request pending.
- rd_ready  output  1  read request accepted this cycle.
- rd_valid  output  1  one-cycle pulse: rd_data holds the sampled word.
- rd_data  output  WIDTH  sampled pin value.
- pins_I  output  WIDTH  data to IOBUF I inputs.
- pins_T  output  1  IOBUF tri-state enable; 1 = hi-Z/input, 0 = drive.
- pins_O  input  WIDTH  IOBUF O outputs (pad value).
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset values:
  - pins_T=1, pins_I=0, wr_ready=0, rd_ready=0, rd_valid=0, rd_data=0, busy=0.
  - state=IDLE, last_dir=READ, rr_pri=WRITE, turn_cnt=0.
- RST asserted mid-transaction: immediate return to reset values next edge; an in-flight read produces no rd_valid; the bus goes hi-Z.
- State machine states: IDLE, TURN, DRIVE, SAMPLE.
- IDLE:
  - Arbitrate wr_valid vs rd_req. When both are pending, grant rr_pri, then flip rr_pri to the other requester.
  - Grant WRITE: wr_ready=1 this cycle and capture wr_data.
    - If last_dir=WRITE, go to DRIVE.
    - Otherwise load turn_cnt=TURN_CYCLES and go to TURN.
  - Grant READ: rd_ready=1 this cycle.
    - If last_dir=READ, go to SAMPLE.
    - Otherwise go to TURN.
- TURN:
  - pins_T=1 (bus released). Decrement turn_cnt; at 1 go to the pending target (DRIVE or SAMPLE).
  - A TURN_CYCLES-cycle gap with T=1 always separates the last drive cycle from the first sample cycle, and vice versa.
- DRIVE:
  - pins_T=0, pins_I=captured word, exactly 1 cycle; last_dir=WRITE.
  - Back-to-back writes (wr_valid held, no read pending or write has priority) re-enter DRIVE via IDLE with T kept 0.
    - IDLE keeps pins_T=0 when last_dir=WRITE; the bus is parked driven.
  - Throughput: 1 write per 2 cycles.
- SAMPLE:
  - pins_T=1; register pins_O into rd_data; rd_valid=1 on the following cycle; last_dir=READ.
  - Read latency from rd_ready: 2 cycles when no turnaround, 2+TURN_CYCLES otherwise.
- pins_I holds its last driven value while T=1 (no glitching), so it changes only on DRIVE entry.
- Simultaneous wr_valid and rd_req: strict alternation; neither requester starves; a request dropped before ready simply drops.
- turn_cnt is 4 bits; TURN_CYCLES=0 is illegal and trapped by an elaboration assertion.

Optional Feature:
- IOBUF_VEC_CTL_SYNC_EN defined:
  - pins_O passes through a 2-flop synchronizer (reset 0) before the SAMPLE capture.
  - SAMPLE extends by 2 cycles (counter-held); read latency +2.
  - For asynchronous external devices.
- Undefined: direct capture as above, with no synchronizer flops present.

Decomposition:
- Package iobuf_vec_ctl_pkg:
  - enum ctl_state_t {IDLE, TURN, DRIVE, SAMPLE}
  - enum dir_t {DIR_READ, DIR_WRITE}
  - localparam TURN_CNT_W=4
- Sub-module iobuf_rr_arb2: 2-request round-robin arbiter (req[1:0], advance, grant[1:0], pri flop), reused by future pin controllers.

Test Plan:
- Reset → pins_T=1, pins_I=0, rd_valid=0, busy=0. Assert RST during TURN → T=1 next edge, no rd_valid ever.
- Single write 8'hA5 after reset (last_dir=READ, TURN_CYCLES=1) → wr_ready cycle 0, TURN cycle 1 with T=1, DRIVE cycle 2 with T=0 and pins_I=A5.
- Write A5 then read with pins_O=8'h3C → T=0 on the drive cycle, at least 1 cycle T=1 before sample, rd_valid with rd_data=3C; T never 0 on a sample cycle.
- Both wr_valid and rd_req held for 8 grants → grants alternate W,R,W,R…; count 4 each; TURN inserted between every pair.
- TURN_CYCLES=3, read after write → exactly 3 consecutive T=1 idle cycles before SAMPLE; read latency 5 cycles.
- With IOBUF_VEC_CTL_SYNC_EN, read with no prior write, pins_O=8'hFF → rd_valid at cycle 4 from rd_ready, rd_data=FF; without the macro, at cycle 2.
